// File: rtl/instruction_fetch_ctrl.sv
// Instruction fetch controller: walks a PC through instruction memory, registers one
// instruction per cycle for the downstream stage, and stops when it fetches the halt opcode.
module instruction_fetch_ctrl #(
    parameter int unsigned MEM_DEPTH   = 64,
    parameter logic [7:0]  HALT_OPCODE = 8'b1111_1111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] start_address,
    output logic [7:0] instruction_address,
    input  logic [7:0] instruction_data,
    input  logic       branch_taken,
    input  logic [7:0] branch_target,
    output logic       fetch_valid,
    input  logic       fetch_ready,
    output logic [7:0] fetch_instruction,
    output logic [7:0] fetch_pc,
    output logic       halted
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    // MEM_DEPTH is a power of two, so "mod MEM_DEPTH" is a mask on the low bits.
    localparam logic [7:0] PC_MASK = 8'(MEM_DEPTH - 1);

    logic [1:0] state;
    logic [7:0] pc;
    logic [7:0] pc_inc;
    logic       capture;
    logic       halt_hit;

    assign instruction_address = pc;
    assign halted              = (state == ST_HALT);
    assign pc_inc              = (pc + 8'd1) & PC_MASK;
    assign halt_hit            = (instruction_data == HALT_OPCODE);

    // A branch always wins over capture: the instruction at the old PC is wrong-path.
    assign capture = (state == ST_FETCH) && !branch_taken && (!fetch_valid || fetch_ready);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values and the order of statements within the block cannot matter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            pc    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pc    <= start_address & PC_MASK;
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (branch_taken) begin
                        pc <= branch_target & PC_MASK;
                    end else if (capture) begin
                        // The halt instruction's own address is kept so the PC points at it.
                        if (halt_hit) state <= ST_HALT;
                        else          pc    <= pc_inc;
                    end
                end
                ST_HALT: begin
                    if (start && !fetch_valid) begin
                        pc    <= start_address & PC_MASK;
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the output data registers are reset too, so fetch_instruction/fetch_pc
    // read as zero after reset rather than holding stale values from before it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_valid       <= 1'b0;
            fetch_instruction <= '0;
            fetch_pc          <= '0;
        end else if (capture) begin
            fetch_valid       <= 1'b1;
            fetch_instruction <= instruction_data;
            fetch_pc          <= pc;
        end else if ((state == ST_FETCH) && branch_taken) begin
            fetch_valid <= 1'b0;
        end else if (fetch_valid && fetch_ready) begin
            fetch_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Self-checking bench for instruction_fetch_ctrl: directed scenarios followed by random
// traffic, all compared every cycle against a behavioural model of the fetch stream.
module tb_instruction_fetch_ctrl;

    localparam int         MD   = 64;
    localparam logic [7:0] HALT = 8'hFF;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] start_address;
    logic [7:0] instruction_address;
    logic [7:0] instruction_data;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic       fetch_valid;
    logic       fetch_ready;
    logic [7:0] fetch_instruction;
    logic [7:0] fetch_pc;
    logic       halted;

    logic [7:0] mem [256];

    int total = 0;
    int bad   = 0;

    // Reference model: what the downstream stage should see, in program-order terms.
    typedef enum {M_IDLE, M_RUN, M_HALT} mode_t;
    mode_t      m_mode;
    int         m_pc;
    bit         m_valid;
    logic [7:0] m_instr;
    logic [7:0] m_fpc;

    instruction_fetch_ctrl #(.MEM_DEPTH(MD), .HALT_OPCODE(HALT)) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .start_address       (start_address),
        .instruction_address (instruction_address),
        .instruction_data    (instruction_data),
        .branch_taken        (branch_taken),
        .branch_target       (branch_target),
        .fetch_valid         (fetch_valid),
        .fetch_ready         (fetch_ready),
        .fetch_instruction   (fetch_instruction),
        .fetch_pc            (fetch_pc),
        .halted              (halted)
    );

    assign instruction_data = mem[instruction_address];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_pc    = 0;
        m_valid = 1'b0;
        m_instr = 8'h00;
        m_fpc   = 8'h00;
    endtask

    // One rising edge of the model, using the inputs as they stood at that edge.
    task automatic model_step();
        case (m_mode)
            M_IDLE: begin
                if (start) begin
                    m_pc   = int'(start_address) % MD;
                    m_mode = M_RUN;
                end
            end
            M_RUN: begin
                if (branch_taken) begin
                    m_pc    = int'(branch_target) % MD;
                    m_valid = 1'b0;
                end else if (!(m_valid && !fetch_ready)) begin
                    m_valid = 1'b1;
                    m_instr = mem[m_pc];
                    m_fpc   = 8'(m_pc);
                    if (mem[m_pc] == HALT) m_mode = M_HALT;
                    else                   m_pc   = (m_pc + 1) % MD;
                end
            end
            M_HALT: begin
                if (m_valid) begin
                    if (fetch_ready) m_valid = 1'b0;
                end else if (start) begin
                    m_pc   = int'(start_address) % MD;
                    m_mode = M_RUN;
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic compare_all(input string where);
        chk({where, "_valid"},  {7'd0, fetch_valid}, {7'd0, m_valid});
        chk({where, "_halted"}, {7'd0, halted}, {7'd0, (m_mode == M_HALT)});
        chk({where, "_addr"},   instruction_address, 8'(m_pc));
        chk({where, "_instr"},  fetch_instruction, m_instr);
        chk({where, "_fpc"},    fetch_pc, m_fpc);
    endtask

    task automatic tick(input string where);
        @(posedge clk);
        #1;
        model_step();
        compare_all(where);
    endtask

    // Asynchronous reset pulse placed between edges; outputs must clear with no clock.
    task automatic do_reset(input string where);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        compare_all(where);
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        start         = 1'b0;
        start_address = 8'd0;
        fetch_ready   = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 8'd0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i + 1);

        // Power-on reset held across an edge.
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        compare_all("por");
        @(posedge clk);
        #1;
        reset = 1'b0;
        compare_all("por_edge");

        // Streaming from address 0 with downstream always ready.
        start = 1'b1; start_address = 8'd0; fetch_ready = 1'b1;
        tick("start");
        chk("start_no_valid_yet", {7'd0, fetch_valid}, 8'd0);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick("stream");
            chk("stream_instr", fetch_instruction, 8'(k + 1));
            chk("stream_pc", fetch_pc, 8'(k));
            chk("stream_valid", {7'd0, fetch_valid}, 8'd1);
        end

        // Branch back to 0, stream to pc 2, then stall three cycles.
        branch_taken = 1'b1; branch_target = 8'd0;
        tick("br0");
        chk("br0_bubble", {7'd0, fetch_valid}, 8'd0);
        branch_taken = 1'b0;
        repeat (3) tick("refill");
        chk("refill_pc", fetch_pc, 8'd2);
        fetch_ready = 1'b0;
        repeat (3) begin
            tick("stall");
            chk("stall_pc", fetch_pc, 8'd2);
            chk("stall_instr", fetch_instruction, 8'h03);
            chk("stall_addr", instruction_address, 8'd3);
        end
        fetch_ready = 1'b1;
        tick("release");
        chk("release_pc", fetch_pc, 8'd3);

        // Branch with simultaneous fetch_ready, in-range and out-of-range targets.
        branch_taken = 1'b1; branch_target = 8'd40;
        tick("br40");
        chk("br40_bubble", {7'd0, fetch_valid}, 8'd0);
        branch_taken = 1'b0;
        tick("br40_tgt");
        chk("br40_pc", fetch_pc, 8'd40);
        chk("br40_instr", fetch_instruction, 8'd41);
        branch_taken = 1'b1; branch_target = 8'd200;
        tick("br200");
        chk("br200_bubble", {7'd0, fetch_valid}, 8'd0);
        branch_taken = 1'b0;
        tick("br200_tgt");
        chk("br200_pc", fetch_pc, 8'd8);

        // Wrap past MEM_DEPTH-1 into a halt at address 0.
        do_reset("rst_pre_halt");
        mem[62] = 8'h10; mem[63] = 8'h11; mem[0] = HALT;
        start = 1'b1; start_address = 8'd62;
        tick("start62");
        start = 1'b0;
        tick("wrap62");
        chk("wrap62_pc", fetch_pc, 8'd62);
        tick("wrap63");
        chk("wrap63_pc", fetch_pc, 8'd63);
        chk("wrap63_instr", fetch_instruction, 8'h11);
        tick("wrap0");
        chk("wrap0_pc", fetch_pc, 8'd0);
        chk("halt_instr", fetch_instruction, HALT);
        chk("halt_flag", {7'd0, halted}, 8'd1);
        tick("halt_drain");
        chk("halt_drained", {7'd0, fetch_valid}, 8'd0);
        chk("halt_addr", instruction_address, 8'd0);
        branch_taken = 1'b1; branch_target = 8'd20;
        tick("halt_branch_ignored");
        chk("halt_branch_addr", instruction_address, 8'd0);
        branch_taken = 1'b0;

        // Restart from HALT at address 5.
        start = 1'b1; start_address = 8'd5;
        tick("restart");
        chk("restart_halted", {7'd0, halted}, 8'd0);
        start = 1'b0;
        tick("restart_first");
        chk("restart_pc", fetch_pc, 8'd5);
        tick("restart_next");

        // Reset in the middle of a stall; nothing may appear until a new start.
        fetch_ready = 1'b0;
        tick("pre_rst_stall");
        do_reset("rst_mid_stall");
        chk("rst_valid", {7'd0, fetch_valid}, 8'd0);
        chk("rst_addr", instruction_address, 8'd0);
        fetch_ready = 1'b1;
        repeat (3) tick("post_rst_idle");
        chk("post_rst_valid", {7'd0, fetch_valid}, 8'd0);

        // Random traffic against the model.
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom % 8 == 0) ? HALT : 8'($urandom);
        do_reset("rst_rand");
        for (int n = 0; n < 1500; n++) begin
            start         = ($urandom % 4 == 0);
            start_address = 8'($urandom);
            fetch_ready   = ($urandom % 10 < 7);
            branch_taken  = ($urandom % 10 == 0);
            branch_target = 8'($urandom);
            if ($urandom % 200 == 0) do_reset("rand_rst");
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_ctrl.md
INSTRUCTION_FETCH_CTRL -- requirements
Module: instruction_fetch_ctrl

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 64, number of instruction memory words (power of two, 2..256).
REQ-002 SHALL have parameter HALT_OPCODE, default 8'b1111_1111, instruction encoding that stops fetching.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin fetching at start_address; sampled only in IDLE or HALT.
REQ-006 SHALL have port start_address  input  8  first PC after start.
REQ-007 SHALL have port instruction_address  output  8  PC driven to instruction memory.
REQ-008 SHALL have port instruction_data  input  8  combinational memory read data for instruction_address.
REQ-009 SHALL have port branch_taken  input  1  redirect request from downstream.
REQ-010 SHALL have port branch_target  input  8  redirect PC.
REQ-011 SHALL have port fetch_valid  output  1  fetch_instruction/fetch_pc hold a valid instruction.
REQ-012 SHALL have port fetch_ready  input  1  downstream accepts the instruction this cycle.
REQ-013 SHALL have port fetch_instruction  output  8  registered instruction.
REQ-014 SHALL have port fetch_pc  output  8  address the instruction was fetched from.
REQ-015 SHALL have port halted  output  1  high while in HALT.

Function
REQ-016 SHALL implement states IDLE, FETCH, HALT; halted = (state == HALT).
REQ-017 SHALL drive instruction_address = pc combinationally from a pc register.
REQ-018 SHALL, in IDLE with start=1, load pc <= start_address mod MEM_DEPTH and enter FETCH next edge.
REQ-019 SHALL define capture = FETCH && !branch_taken && (!fetch_valid || fetch_ready).
REQ-020 SHALL, on capture, register fetch_instruction <= instruction_data, fetch_pc <= pc, fetch_valid <= 1.
REQ-021 SHALL, on capture of non-halt data, advance pc <= (pc + 1) mod MEM_DEPTH; MEM_DEPTH-1 wraps to 0.
REQ-022 SHALL, when fetch_valid=1 and fetch_ready=0 in FETCH without branch, hold pc and all fetch_* outputs unchanged (stall).
REQ-023 SHALL, when fetch_valid=1, fetch_ready=1 and no capture occurs, clear fetch_valid next edge.
REQ-024 SHALL, on branch_taken=1 in FETCH, load pc <= branch_target mod MEM_DEPTH and clear fetch_valid; the buffered instruction is dropped even if fetch_ready=1 that cycle.
REQ-025 SHALL, on capture of data equal to HALT_OPCODE, deliver it normally, keep pc at the halt address, and enter HALT.
REQ-026 SHALL ignore branch_taken in IDLE and HALT.
REQ-027 SHALL, in HALT, keep fetch_valid until accepted via fetch_ready, then clear it.
REQ-028 SHALL, in HALT with start=1 and fetch_valid=0, load pc <= start_address mod MEM_DEPTH and enter FETCH; start is ignored while fetch_valid=1.
REQ-029 SHALL have latency: start sampled at edge N -> first fetch_valid=1 after edge N+1; branch at edge N -> target instruction valid after edge N+1.
REQ-030 SHALL sustain one instruction per cycle when fetch_ready is held high.

Reset
REQ-031 SHALL, on reset=1, immediately set state=IDLE, pc=0, fetch_valid=0, fetch_instruction=0, fetch_pc=0, halted=0, regardless of clk.
REQ-032 SHALL, on reset asserted mid-stall or mid-branch, discard all in-flight state; no instruction is presented after reset until a new start.

Verification
REQ-033 SHALL cover streaming: mem[0..3]=8'h01..8'h04, start_address=0, fetch_ready=1 -> fetch_instruction 01,02,03,04 on consecutive cycles with fetch_pc 0..3.
REQ-034 SHALL cover stall: fetch_ready=0 for 3 cycles while fetch_pc=2 -> fetch_instruction, fetch_pc and instruction_address constant; release -> fetch_pc=3 next cycle.
REQ-035 SHALL cover branch with simultaneous fetch_ready: branch_taken=1, branch_target=8'd40 -> fetch_valid=0 one cycle, then fetch_pc=40; an out-of-range target 8'd200 yields fetch_pc=8 (MEM_DEPTH=64).
REQ-036 SHALL cover wrap and halt: start_address=62, mem[62]=8'h10, mem[63]=8'h11, mem[0]=8'hFF -> fetch_pc 62,63,0; halted=1 after 8'hFF captured; instruction_address stays 0.
REQ-037 SHALL cover restart and reset: in HALT with fetch_valid=0, start=1, start_address=5 -> fetch_pc=5; reset asserted mid-stream -> fetch_valid=0, pc=0 without a clock edge.
